// File: rtl/rv32imc_types.sv
// Shared types for the instruction-fetch front end.
package rv32imc_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [3:0] IMEM_RMASK_WORD = 4'hF;
  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, inst} pairs; clear wins over push and pop.
module fetch_fifo
  import rv32imc_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_inst,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  fetch_entry_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_pc   = mem_q[rd_ptr_q].pc;
  assign head_inst = mem_q[rd_ptr_q].inst;

  always_comb begin
    do_push  = push && !clear;
    do_pop   = pop && !empty && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointers are log2(DEPTH) wide, so the increment wraps on its own
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= '{pc: push_pc, inst: push_inst};
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) assert (!full);
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding imem request, results buffered in fetch_fifo.
module fetch_queue
  import rv32imc_types::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  input  logic        i_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [CW-1:0] count, post_count;
  logic          fifo_full, fifo_empty;
  logic          in_flight, push, pop;

  assign in_flight  = (state_q == REQ) || (state_q == DISCARD);
  assign push       = (state_q == REQ) && imem_resp && !i_flush;
  assign pop        = o_valid && i_ready && !i_flush;
  assign post_count = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      IDLE: begin
        if (!i_flush && !fifo_full) state_d = REQ;
      end
      REQ: begin
        if (imem_resp) begin
          state_d = (!i_flush && (post_count < DEPTH_C)) ? REQ : IDLE;
        end else if (i_flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_flush)   fetch_pc_d = i_redirect_pc & ~32'h3;
    else if (push) fetch_pc_d = fetch_pc_q + PC_STEP;

    // The bus address is frozen while a request is outstanding, even across a
    // redirect; otherwise it follows the next fetch pc so a new issue is ready.
    req_addr_d = (in_flight && !imem_resp) ? req_addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_addr  = req_addr_q;
  assign imem_rmask = in_flight ? IMEM_RMASK_WORD : 4'h0;
  assign o_valid    = !fifo_empty;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (i_flush),
    .push      (push),
    .push_pc   (fetch_pc_q),
    .push_inst (imem_rdata),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head_pc   (o_pc),
    .head_inst (o_inst)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: three instances (DEPTH 4, 2, 8), each with its own memory model.
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] redirect = 32'h0;
  logic        rand_mode = 1'b0;
  int          fixed_lat = 0;

  logic [3:0]  rmask_a, rmask_b, rmask_c;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        resp_a, resp_b, resp_c;
  logic        valid_a, valid_b, valid_c;
  logic [31:0] pc_a, pc_b, pc_c;
  logic [31:0] inst_a, inst_b, inst_c;

  int wait_a = 0, wait_b = 0, wait_c = 0;
  int lat_a = 0, lat_b = 0, lat_c = 0;

  int n_run = 0;
  int n_fail = 0;

  // reference instruction memory contents
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a0f0f;
  endfunction

  assign resp_a  = (rmask_a == 4'hF) && (wait_a >= (rand_mode ? lat_a : fixed_lat));
  assign resp_b  = (rmask_b == 4'hF) && (wait_b >= (rand_mode ? lat_b : fixed_lat));
  assign resp_c  = (rmask_c == 4'hF) && (wait_c >= (rand_mode ? lat_c : fixed_lat));
  assign rdata_a = resp_a ? memf(addr_a) : 32'h0;
  assign rdata_b = resp_b ? memf(addr_b) : 32'h0;
  assign rdata_c = resp_c ? memf(addr_c) : 32'h0;

  always @(posedge clk) begin
    if (rst)                   begin wait_a <= 0; lat_a <= 0; end
    else if (resp_a)           begin wait_a <= 0; lat_a <= $urandom_range(0, 5); end
    else if (rmask_a == 4'hF)  wait_a <= wait_a + 1;
    else                       wait_a <= 0;
    if (rst)                   begin wait_b <= 0; lat_b <= 0; end
    else if (resp_b)           begin wait_b <= 0; lat_b <= $urandom_range(0, 5); end
    else if (rmask_b == 4'hF)  wait_b <= wait_b + 1;
    else                       wait_b <= 0;
    if (rst)                   begin wait_c <= 0; lat_c <= 0; end
    else if (resp_c)           begin wait_c <= 0; lat_c <= $urandom_range(0, 5); end
    else if (rmask_c == 4'hF)  wait_c <= wait_c + 1;
    else                       wait_c <= 0;
  end

  fetch_queue #(.DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .i_flush(flush), .i_redirect_pc(redirect),
    .imem_addr(addr_a), .imem_rmask(rmask_a), .imem_rdata(rdata_a), .imem_resp(resp_a),
    .o_valid(valid_a), .o_pc(pc_a), .o_inst(inst_a), .i_ready(ready)
  );
  fetch_queue #(.DEPTH(2)) dut_b (
    .clk(clk), .rst(rst), .i_flush(flush), .i_redirect_pc(redirect),
    .imem_addr(addr_b), .imem_rmask(rmask_b), .imem_rdata(rdata_b), .imem_resp(resp_b),
    .o_valid(valid_b), .o_pc(pc_b), .o_inst(inst_b), .i_ready(ready)
  );
  fetch_queue #(.DEPTH(8)) dut_c (
    .clk(clk), .rst(rst), .i_flush(flush), .i_redirect_pc(redirect),
    .imem_addr(addr_c), .imem_rmask(rmask_c), .imem_rdata(rdata_c), .imem_resp(resp_c),
    .o_valid(valid_c), .o_pc(pc_c), .o_inst(inst_c), .i_ready(ready)
  );

  // Model per lane: the queue of instructions owed to decode, the next pc the
  // unit must fetch, whether the outstanding response belongs to a dead stream,
  // and the bus request mask the rules demand for the coming cycle.
  logic [63:0] mq [3][$];
  logic [31:0] fpc [3];
  logic        disc [3];
  logic [3:0]  exp_rm [3];
  logic        armed [3];
  int          deliv [3];

  task automatic cmp(input int l, input string nm, input logic [31:0] act, input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL lane%0d %s at %0t: got %h expected %h", l, nm, $time, act, want);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end else begin
      $display("[TB] %s = %h ok", nm, act);
    end
  endtask

  task automatic check_lane(input int l);
    logic [3:0]  rm;
    logic [31:0] ad, pc, in;
    logic        rs, vd, pop, acc;
    logic [63:0] head;
    int          dep, s0;
    case (l)
      0:       begin rm = rmask_a; ad = addr_a; rs = resp_a; vd = valid_a; pc = pc_a; in = inst_a; dep = 4; end
      1:       begin rm = rmask_b; ad = addr_b; rs = resp_b; vd = valid_b; pc = pc_b; in = inst_b; dep = 2; end
      default: begin rm = rmask_c; ad = addr_c; rs = resp_c; vd = valid_c; pc = pc_c; in = inst_c; dep = 8; end
    endcase
    if (rst) begin
      mq[l].delete();
      fpc[l]    = RST_PC;
      disc[l]   = 1'b0;
      exp_rm[l] = 4'h0;
      armed[l]  = 1'b1;
      return;
    end
    if (!armed[l]) return;

    s0 = mq[l].size();
    cmp(l, "rmask", {28'h0, rm}, {28'h0, exp_rm[l]});
    cmp(l, "valid", {31'h0, vd}, {31'h0, (s0 > 0)});
    if (s0 > 0) begin
      head = mq[l][0];
      cmp(l, "o_pc", pc, head[63:32]);
      cmp(l, "o_inst", in, head[31:0]);
    end
    if (rm == 4'hF && !disc[l]) begin
      cmp(l, "imem_addr", ad, fpc[l]);
      cmp(l, "room_at_issue", {31'h0, (s0 < dep)}, 32'h1);
    end

    pop = (s0 > 0) && ready && !flush;
    acc = (rm == 4'hF) && rs && !flush && !disc[l];
    if (flush) begin
      mq[l].delete();
      fpc[l]    = redirect & ~32'h3;
      disc[l]   = (rm == 4'hF) && !rs;
      exp_rm[l] = ((rm == 4'hF) && !rs) ? 4'hF : 4'h0;
    end else begin
      if (pop) begin
        void'(mq[l].pop_front());
        deliv[l]++;
      end
      if (acc) begin
        mq[l].push_back({fpc[l], memf(fpc[l])});
        fpc[l] = fpc[l] + 32'd4;
      end
      if (rm == 4'hF) begin
        if (!rs)          exp_rm[l] = 4'hF;
        else if (disc[l]) exp_rm[l] = 4'h0;
        else              exp_rm[l] = (mq[l].size() < dep) ? 4'hF : 4'h0;
        if (rs) disc[l] = 1'b0;
      end else begin
        exp_rm[l] = (s0 < dep) ? 4'hF : 4'h0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int l = 0; l < 3; l++) check_lane(l);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int bound);
    for (int i = 0; i < bound && !valid_a; i++) tick();
    lit(nm, {31'h0, valid_a}, 32'h1);
  endtask

  initial begin
    int nreq;
    logic [31:0] a;
    for (int l = 0; l < 3; l++) begin
      armed[l] = 1'b0; disc[l] = 1'b0; fpc[l] = RST_PC; exp_rm[l] = 4'h0; deliv[l] = 0;
    end

    // reset state, then back-to-back zero-latency fetch with decode always ready
    fixed_lat = 0;
    rst = 1'b1;
    tick();
    tick();
    lit("reset_valid", {31'h0, valid_a}, 32'h0);
    lit("reset_rmask", {28'h0, rmask_a}, 32'h0);
    lit("reset_addr", addr_a, RST_PC);
    rst = 1'b0;
    ready = 1'b1;
    tick();
    lit("t1_first_req_addr", addr_a, 32'h1eceb000);
    lit("t1_first_req_rmask", {28'h0, rmask_a}, 32'hF);
    tick();
    lit("t1_pc_cycle2", pc_a, 32'h1eceb000);
    tick();
    lit("t1_pc_cycle3", pc_a, 32'h1eceb004);
    tick();
    lit("t1_pc_cycle4", pc_a, 32'h1eceb008);
    lit("t1_inst_cycle4", inst_a, 32'hb0081ece ^ 32'h5a5a0f0f);

    // fill with decode stalled, then release exactly one slot
    do_reset();
    fixed_lat = 0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rmask_a == 4'hF) nreq++;
    end
    lit("t2_requests_until_full", nreq, 4);
    lit("t2_rmask_full", {28'h0, rmask_a}, 32'h0);
    lit("t2_head_pc", pc_a, 32'h1eceb000);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    nreq = 0;
    a = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (rmask_a == 4'hF) begin nreq++; a = addr_a; end
      tick();
    end
    lit("t2_requests_after_pulse", nreq, 1);
    lit("t2_refill_addr", a, 32'h1eceb010);
    lit("t2_head_after_pulse", pc_a, 32'h1eceb004);

    // flush while the 1eceb004 request is stuck for 3 cycles
    do_reset();
    fixed_lat = 0;
    tick();
    tick();
    fixed_lat = 3;
    lit("t3_pending_addr", addr_a, 32'h1eceb004);
    tick();
    flush = 1'b1; redirect = 32'h00000100;
    tick();
    flush = 1'b0;
    lit("t3_addr_held", addr_a, 32'h1eceb004);
    lit("t3_rmask_held", {28'h0, rmask_a}, 32'hF);
    lit("t3_valid_cleared", {31'h0, valid_a}, 32'h0);
    tick();
    lit("t3_addr_at_resp", addr_a, 32'h1eceb004);
    tick();
    lit("t3_idle_after_drop", {28'h0, rmask_a}, 32'h0);
    tick();
    lit("t3_redirect_req", addr_a, 32'h00000100);
    wait_valid("t3_valid_after_redirect", 20);
    lit("t3_first_pc", pc_a, 32'h00000100);
    lit("t3_first_inst", inst_a, memf(32'h00000100));

    // flush coincident with the response
    do_reset();
    fixed_lat = 0;
    tick();
    tick();
    flush = 1'b1; redirect = 32'h00000400;
    tick();
    flush = 1'b0;
    lit("t4_valid_after_flush", {31'h0, valid_a}, 32'h0);
    lit("t4_rmask_after_flush", {28'h0, rmask_a}, 32'h0);
    tick();
    lit("t4_redirect_req", addr_a, 32'h00000400);
    tick();
    lit("t4_first_pc", pc_a, 32'h00000400);

    // two flushes while discarding: the later redirect wins
    do_reset();
    fixed_lat = 0;
    tick();
    tick();
    fixed_lat = 5;
    tick();
    flush = 1'b1; redirect = 32'h00000200;
    tick();
    redirect = 32'h00000300;
    tick();
    flush = 1'b0;
    lit("t5_still_discarding", {28'h0, rmask_a}, 32'hF);
    lit("t5_old_addr", addr_a, 32'h1eceb004);
    wait_valid("t5_valid_after_redirect", 30);
    lit("t5_first_pc", pc_a, 32'h00000300);

    // random latency, decode backpressure and flushes on all three depths
    do_reset();
    for (int l = 0; l < 3; l++) deliv[l] = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 3) < ((i < 1500) ? 1 : 3));
      flush = ($urandom_range(0, 39) == 0);
      redirect = $urandom() & 32'h00fffffc;
      rst = (i == 1700 || i == 1701);
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    tick();
    lit("rand_delivered_depth4", {31'h0, (deliv[0] > 100)}, 32'h1);
    lit("rand_delivered_depth2", {31'h0, (deliv[1] > 100)}, 32'h1);
    lit("rand_delivered_depth8", {31'h0, (deliv[2] > 100)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the queue entry count; a power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h1eceb000, SHALL be the first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 i_flush  input  1  discard queued and in-flight instructions and redirect fetch.
REQ-006 i_redirect_pc  input  32  new fetch address, sampled when i_flush=1.
REQ-007 imem_addr  output  32  fetch address, word aligned.
REQ-008 imem_rmask  output  4  4'hF while a request is outstanding, else 4'h0.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_resp=1.
REQ-010 imem_resp  input  1  single-cycle completion of the outstanding request.
REQ-011 o_valid  output  1  queue head holds a valid instruction.
REQ-012 o_pc  output  32  PC of head instruction.
REQ-013 o_inst  output  32  head instruction word.
REQ-014 i_ready  input  1  decode consumes head this cycle when o_valid=1.

Function
REQ-015 At most one imem request SHALL be outstanding; imem_addr and imem_rmask SHALL stay stable from issue until the cycle imem_resp=1.
REQ-016 FSM states IDLE, REQ, DISCARD SHALL be used; imem_rmask=4'hF exactly in REQ and DISCARD.
REQ-017 IDLE->REQ next cycle when count < DEPTH and i_flush=0; otherwise remain IDLE.
REQ-018 In REQ with imem_resp=1 and i_flush=0: {fetch_pc, imem_rdata} SHALL be enqueued, fetch_pc += 4, next state REQ if post-update count < DEPTH, else IDLE (back-to-back fetch, one instruction per cycle at zero memory latency).
REQ-019 In REQ with i_flush=1 and imem_resp=0: next state DISCARD; imem_addr SHALL stay at the old address until resp.
REQ-020 In REQ or DISCARD with i_flush=1 and imem_resp=1: response SHALL be dropped; next state IDLE.
REQ-021 In DISCARD with imem_resp=1 and i_flush=0: response SHALL be dropped; next state IDLE.
REQ-022 i_flush=1 SHALL empty the queue (o_valid=0 next cycle) and load fetch_pc with i_redirect_pc in any state; repeated flushes in DISCARD keep the latest redirect.
REQ-023 Enqueued entry SHALL appear at the outputs no earlier than the cycle after imem_resp (no bypass).
REQ-024 Dequeue (o_valid & i_ready) and enqueue in the same cycle SHALL leave count unchanged.
REQ-025 A request SHALL be issued only when count < DEPTH, guaranteeing a free slot at response; enqueue into a full queue SHALL never occur (assertion).
REQ-026 i_ready while o_valid=0 SHALL have no effect; i_flush SHALL override a simultaneous dequeue.
REQ-027 Pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH)+1.

Reset
REQ-028 On rst: state IDLE, fetch_pc=RESET_PC, count=0, pointers=0, o_valid=0, imem_rmask=4'h0, imem_addr=RESET_PC.
REQ-029 rst with a request outstanding SHALL abandon it; the memory model is reset concurrently.
REQ-030 rst SHALL take priority over i_flush.

Structure
REQ-031 fetch_state_t (IDLE, REQ, DISCARD) SHALL be declared in rv32imc_types.
REQ-032 Storage SHALL be a sub-module fetch_fifo (parametrised DEPTH circular buffer of {pc, inst}, push/pop/clear, full/empty); the FSM and fetch_pc remain in fetch_queue.

Verification
REQ-033 Reset, imem_resp same cycle as request, i_ready=1 -> o_pc 1eceb000, 1eceb004, 1eceb008 on consecutive cycles from cycle 2.
REQ-034 DEPTH=4, i_ready=0, zero-latency memory -> exactly 4 requests, then rmask=0; one i_ready pulse -> one new request at 1eceb010.
REQ-035 Flush to 0x00000100 while request to 1eceb004 pending 3 cycles -> addr holds 1eceb004 until resp, that word never appears, next request 0x00000100.
REQ-036 Flush coincident with imem_resp -> response dropped, o_valid=0 next cycle, next fetch at redirect.
REQ-037 Two flushes (0x200 then 0x300) during DISCARD -> first delivered o_pc 0x300.
REQ-038 Random i_ready/latency 0-5 cycles, DEPTH=2 and 8 -> o_pc strictly sequential between flushes, no overflow assertion fires.
